// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   DATA_BITS       - payload bits per frame
//   IDLE_LEVEL      - line level when no frame is being sent (mark)
//   uart_tx_state_t - transmitter FSM state encoding
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART transmitter.
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   enable   - count while high; counter is held at zero while low
//   bit_tick - high on the last cycle of each CLKS_PER_BIT-cycle bit period
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8-bit UART transmitter, LSB first, 1 or 2 stop bits.
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   tx_data  - byte to send, captured on acceptance (tx_valid && tx_ready)
//   tx_valid - upstream offers a byte
//   tx_ready - high in IDLE; block can accept a byte
//   tx_out   - registered serial line, idles high
//   tx_busy  - high while a frame is on the line
//   tx_done  - one-cycle pulse on return to IDLE
// Macro UART_TX_PARITY_EN: when defined, a parity bit (even, or odd when
// PARITY_ODD = 1) is sent between the last data bit and the stop bit(s).
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_fsm: illegal parameter value");
    end

    localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    uart_tx_state_t         state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   tx_out_q, tx_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
    // Parity is computed at acceptance because the shift register is
    // consumed while the data bits go out.
    logic                   parity_q, parity_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state_q != IDLE),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_out_d   = tx_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    tx_out_d = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_out_d  = shift_q[0];
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
                        tx_out_d   = parity_q;
`else
                        state_d    = STOP;
                        tx_out_d   = IDLE_LEVEL;
                        stop_idx_d = 1'b0;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_out_d  = shift_q[0];
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    tx_out_d   = IDLE_LEVEL;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = IDLE_LEVEL;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_out_q   <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_out   = tx_out_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: self-checking bench for uart_tx_fsm.
// Three instances with CLKS_PER_BIT = 4:
//   0: STOP_BITS = 1, even parity   1: STOP_BITS = 1, odd parity
//   2: STOP_BITS = 2, even parity
// The reference model lists a frame's bits (start, data LSB first, optional
// parity, stop bits) and expands each to CLKS_PER_BIT cycles.
module tb_uart_tx_fsm;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] vld;
    logic [7:0] dat [3];
    logic [2:0] rdy, out, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_fsm #(.CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_fsm #(.CLKS_PER_BIT(N), .STOP_BITS(1), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_fsm #(.CLKS_PER_BIT(N), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    logic [127:0] e_out, e_busy, e_done, e_rdy;
    int           e_n;
    logic [127:0] o_out, o_busy, o_done, o_rdy;

    function automatic int stops_of(input int s);
        return (s == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int s);
        return (1 + 8 + P + stops_of(s)) * N;
    endfunction

    task automatic m_clear();
        e_out = '0; e_busy = '0; e_done = '0; e_rdy = '0; e_n = 0;
    endtask

    task automatic m_cycle(input logic o, input logic b, input logic d);
        e_out[e_n]  = o;
        e_busy[e_n] = b;
        e_done[e_n] = d;
        e_rdy[e_n]  = ~b;
        e_n++;
    endtask

    task automatic m_idle(input int k);
        repeat (k) m_cycle(1'b1, 1'b0, 1'b0);
    endtask

    // One frame from the cycle after acceptance, plus the tx_done cycle.
    task automatic m_frame(input int s, input logic [7:0] b);
        logic bits[$];
        int   odd;
        odd = (s == 1) ? 1 : 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (P == 1) bits.push_back(((^b) + odd) % 2 == 1);
        for (int i = 0; i < stops_of(s); i++) bits.push_back(1'b1);
        foreach (bits[i]) repeat (N) m_cycle(bits[i], 1'b1, 1'b0);
        m_cycle(1'b1, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int s, input logic [7:0] b);
        vld[s] = 1'b1;
        dat[s] = b;
        @(posedge clk);
        #1;
        vld[s] = 1'b0;
        dat[s] = 8'($urandom);
    endtask

    // Samples n cycles at the falling edge; optionally scrambles tx_data
    // and pulses tx_valid for cycles plo..phi while the frame is in flight.
    task automatic capture(input int s, input int n, input int plo, input int phi, input logic noisy);
        o_out = '0; o_busy = '0; o_done = '0; o_rdy = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            o_out[k]  = out[s];
            o_busy[k] = busy[s];
            o_done[k] = done[s];
            o_rdy[k]  = rdy[s];
            if (noisy) begin
                dat[s] = 8'($urandom);
                vld[s] = (k >= plo && k <= phi);
            end
        end
        vld[s] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vld = '0;
        for (int s = 0; s < 3; s++) dat[s] = 8'($urandom);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (rdy !== 3'b111)  begin n_fail++; $display("FAIL reset_ready: got %b expected 111", rdy); end
        n_tests++; if (out !== 3'b111)  begin n_fail++; $display("FAIL reset_out: got %b expected 111", out); end
        n_tests++; if (busy !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b expected 000", busy); end
        n_tests++; if (done !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b expected 000", done); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (rdy !== 3'b111)  begin n_fail++; $display("FAIL post_reset_ready: got %b expected 111", rdy); end
        n_tests++; if (out !== 3'b111)  begin n_fail++; $display("FAIL post_reset_out: got %b expected 111", out); end
        n_tests++; if (busy !== 3'b000 || done !== 3'b000) begin
            n_fail++; $display("FAIL post_reset_busy_done: got %b/%b expected 000/000", busy, done);
        end
    endtask

    task automatic test_single_frame(input string name, input int s, input logic [7:0] b, input logic noisy);
        int len;
        len = frame_len(s);
        m_clear();
        m_frame(s, b);
        m_idle(2);
        sync();
        n_tests++; if (rdy[s] !== 1'b1) begin n_fail++; $display("FAIL %s_ready_before: got %b expected 1", name, rdy[s]); end
        accept(s, b);
        capture(s, e_n, len / 3, len / 3 + 2, noisy);
        n_tests++; if (o_out !== e_out)   begin n_fail++; $display("FAIL %s_out (byte %h dut %0d): got %h expected %h", name, b, s, o_out, e_out); end
        n_tests++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL %s_busy (byte %h dut %0d): got %h expected %h", name, b, s, o_busy, e_busy); end
        n_tests++; if (o_done !== e_done) begin n_fail++; $display("FAIL %s_done (byte %h dut %0d): got %h expected %h", name, b, s, o_done, e_done); end
        n_tests++; if (o_rdy !== e_rdy)   begin n_fail++; $display("FAIL %s_ready (byte %h dut %0d): got %h expected %h", name, b, s, o_rdy, e_rdy); end
    endtask

    task automatic test_random();
        int          s;
        logic [7:0]  b;
        for (int i = 0; i < 6; i++) begin
            s = $urandom_range(0, 2);
            b = 8'($urandom);
            test_single_frame("random", s, b, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        len = frame_len(0);
        m_clear();
        m_frame(0, 8'h3C);
        m_frame(0, 8'hC3);
        m_idle(2);
        sync();
        n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_before: got %b expected 1", rdy[0]); end
        vld[0] = 1'b1;
        dat[0] = 8'h3C;
        @(posedge clk);
        #1;
        dat[0] = 8'hC3;
        o_out = '0; o_busy = '0; o_done = '0; o_rdy = '0;
        for (int k = 0; k < e_n; k++) begin
            @(negedge clk);
            o_out[k]  = out[0];
            o_busy[k] = busy[0];
            o_done[k] = done[0];
            o_rdy[k]  = rdy[0];
            if (k == 8)       dat[0] = 8'h77;
            if (k == 11)      dat[0] = 8'hC3;
            if (k == len + 1) vld[0] = 1'b0;
        end
        vld[0] = 1'b0;
        n_tests++; if (o_out !== e_out)   begin n_fail++; $display("FAIL b2b_out: got %h expected %h", o_out, e_out); end
        n_tests++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL b2b_busy: got %h expected %h", o_busy, e_busy); end
        n_tests++; if (o_done !== e_done) begin n_fail++; $display("FAIL b2b_done: got %h expected %h", o_done, e_done); end
    endtask

    task automatic test_reset_midframe();
        sync();
        accept(0, 8'h96);
        // Third data bit spans cycles 12..15 after acceptance.
        repeat (14) @(negedge clk);
        n_tests++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy[0]); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (out[0] !== 1'b1)  begin n_fail++; $display("FAIL midreset_out: got %b expected 1", out[0]); end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy[0]); end
        n_tests++; if (rdy[0] !== 1'b1)  begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", rdy[0]); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        m_idle(12);
        capture(0, e_n, 0, 0, 1'b0);
        n_tests++; if (o_out !== e_out)   begin n_fail++; $display("FAIL midreset_idle_out: got %h expected %h", o_out, e_out); end
        n_tests++; if (o_busy !== e_busy) begin n_fail++; $display("FAIL midreset_idle_busy: got %h expected %h", o_busy, e_busy); end
        n_tests++; if (o_done !== e_done) begin n_fail++; $display("FAIL midreset_idle_done: got %h expected %h", o_done, e_done); end
    endtask

    initial begin
        test_reset();
        test_single_frame("byte_a5", 0, 8'hA5, 1'b0);
        test_single_frame("even_01", 0, 8'h01, 1'b0);
        test_single_frame("odd_01",  1, 8'h01, 1'b0);
        test_single_frame("byte_ff", 0, 8'hFF, 1'b0);
        test_single_frame("stop2_00", 2, 8'h00, 1'b0);
        test_back_to_back();
        test_reset_midframe();
        test_single_frame("after_reset_5a", 0, 8'h5A, 1'b0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
